apb_host_bridge: RTL and testbench

//  Converts the core-side valid/ready request channel into APB3 setup/access transfers for the

---
 rtl/apb_host_bridge_pkg.sv | 22 ++
 rtl/apb_host_bridge_if.sv | 43 ++++
 rtl/apb_host_bridge_slv_decode.sv | 28 ++
 rtl/apb_host_bridge.sv | 141 ++++++++++++++
 tb/tb_apb_host_bridge.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_host_bridge_pkg.sv
// Shared types and default widths for the host-to-APB bridge and its slave decoder.
package apb_host_bridge_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_PADDR_W = 12;
    localparam int DEF_NUM_SLV = 4;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_br_state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
    } apb_br_rsp_t;

    // A single slave still gets a 1-bit index so the out-of-range check stays meaningful.
    function automatic int sidx_w(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

endpackage

// File: rtl/apb_host_bridge_if.sv
// Host request/response channel plus APB3 bus, bundled for the bridge and its environment.
interface apb_host_bridge_if
    import apb_host_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PADDR_W = DEF_PADDR_W,
    parameter int NUM_SLV = DEF_NUM_SLV
) ();

    logic               req_valid_i;
    logic               req_ready_o;
    logic [ADDR_W-1:0]  req_addr_i;
    logic               req_we_i;
    logic [DATA_W-1:0]  req_wdata_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [DATA_W-1:0]  rsp_rdata_o;
    logic               rsp_err_o;
    logic [PADDR_W-1:0] paddr_o;
    logic [NUM_SLV-1:0] psel_o;
    logic               penable_o;
    logic               pwrite_o;
    logic [DATA_W-1:0]  pwdata_o;
    logic [DATA_W-1:0]  prdata_i;
    logic               pready_i;
    logic               pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, rsp_ready_i,
               prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, rsp_ready_i,
               prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
    );

endinterface

// File: rtl/apb_host_bridge_slv_decode.sv
// Combinational address decoder: host byte address -> one-hot APB select and decode error.
module apb_slv_decode
    import apb_host_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PADDR_W = DEF_PADDR_W,
    parameter int NUM_SLV = DEF_NUM_SLV
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               dec_err_o
);

    localparam int              SIDX_W    = sidx_w(NUM_SLV);
    localparam int              TOP_LSB   = PADDR_W + SIDX_W;
    localparam logic [SIDX_W:0] NUM_SLV_L = (SIDX_W + 1)'(NUM_SLV);

    logic [SIDX_W-1:0] idx;
    logic              upper_nz;
    logic              idx_oob;

    assign idx       = addr_i[PADDR_W +: SIDX_W];
    assign upper_nz  = |(addr_i >> TOP_LSB);
    assign idx_oob   = {1'b0, idx} >= NUM_SLV_L;
    assign dec_err_o = upper_nz | idx_oob;
    assign sel_o     = dec_err_o ? '0 : (NUM_SLV'(1) << idx);

endmodule

// File: rtl/apb_host_bridge.sv
// Host valid/ready to APB3 bridge: one transfer in flight, address decode, wait-state watchdog.
module apb_host_bridge
    import apb_host_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PADDR_W = DEF_PADDR_W,
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    apb_host_bridge_if.master bus
);

    // The counter only has to reach TIMEOUT-1; it saturates when the watchdog is disabled.
    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_br_state_e      state_q, state_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic [PADDR_W-1:0] paddr_q, paddr_d;
    logic               pwrite_q, pwrite_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               rsp_valid_q, rsp_valid_d;
    apb_br_rsp_t        rsp_q, rsp_d;

    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_err;
    logic               req_ready;

    apb_slv_decode #(
        .ADDR_W  (ADDR_W),
        .PADDR_W (PADDR_W),
        .NUM_SLV (NUM_SLV)
    ) u_dec (
        .addr_i    (bus.req_addr_i),
        .sel_o     (dec_sel),
        .dec_err_o (dec_err)
    );

    assign req_ready = (state_q == IDLE) & ~rst_i;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && req_ready) begin
                    if (dec_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_d.rdata = '0;
                        rsp_d.err   = 1'b1;
                    end else begin
                        state_d  = SETUP;
                        psel_d   = dec_sel;
                        paddr_d  = bus.req_addr_i[PADDR_W-1:0];
                        pwrite_d = bus.req_we_i;
                        pwdata_d = bus.req_wdata_i;
                        wait_d   = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    state_d     = RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d.rdata = pwrite_q ? '0 : bus.prdata_i;
                    rsp_d.err   = bus.pslverr_i;
                end else if ((TIMEOUT != 0) && (wait_q == TO_LAST)) begin
                    state_d     = RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d.rdata = '0;
                    rsp_d.err   = 1'b1;
                end else if (wait_q != {CNT_W{1'b1}}) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_q.rdata;
    assign bus.rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_apb_host_bridge.sv
// Scoreboard bench for apb_host_bridge with a simple wait-state APB slave model.
module tb_apb_host_bridge;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   t_acc = 0;

    exp_rsp_t sb[$];

    // slave model knobs
    int          ws = 0;
    bit          stuck = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        s_err = 1'b0;
    int          acc_cnt = 0;

    apb_host_bridge_if #(.ADDR_W(32), .DATA_W(32), .PADDR_W(12), .NUM_SLV(4)) bif ();

    apb_host_bridge #(
        .ADDR_W(32), .DATA_W(32), .PADDR_W(12), .NUM_SLV(4), .TIMEOUT(8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        acc_cnt <= ((bif.psel_o != 0) && bif.penable_o && !bif.pready_i) ? acc_cnt + 1 : 0;

    assign bif.pready_i  = stuck ? 1'b0 : (acc_cnt >= ws);
    assign bif.prdata_i  = s_rdata;
    assign bif.pslverr_i = s_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // scoreboard: compare each response at its handshake
    always @(negedge clk) begin
        if (!rst && bif.rsp_valid_o && bif.rsp_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 1, 0);
            end else begin
                exp_rsp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", bif.rsp_rdata_o, e.rdata);
                chk("rsp_err", bif.rsp_err_o, e.err);
            end
        end
    end

    task automatic send(input logic [31:0] addr, input logic we, input logic [31:0] wd);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        bif.req_valid_i = 1'b1;
        bif.req_addr_i  = addr;
        bif.req_we_i    = we;
        bif.req_wdata_i = wd;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (bif.req_ready_o) begin
                acc   = 1'b1;
                t_acc = cyc;
            end
        end
        if (!acc) chk("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        bif.req_valid_i = 1'b0;
        bif.req_addr_i  = '0;
        bif.req_wdata_i = '0;
    endtask

    task automatic wait_rsp(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bif.rsp_valid_o) begin
                seen = 1'b1;
                lat  = cyc - t_acc;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) chk("rsp_wait_timeout", 0, 1);
    endtask

    task automatic finish_hs();
        @(posedge clk); #1;
        chk("rsp_valid_clear", bif.rsp_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int n_acc;
        bif.req_valid_i = 1'b0;
        bif.req_addr_i  = '0;
        bif.req_we_i    = 1'b0;
        bif.req_wdata_i = '0;
        bif.rsp_ready_i = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_psel", bif.psel_o, 0);
        chk("rst_penable", bif.penable_o, 0);
        chk("rst_pwrite", bif.pwrite_o, 0);
        chk("rst_paddr", bif.paddr_o, 0);
        chk("rst_pwdata", bif.pwdata_o, 0);
        chk("rst_rsp_valid", bif.rsp_valid_o, 0);
        chk("rst_rsp_rdata", bif.rsp_rdata_o, 0);
        chk("rst_rsp_err", bif.rsp_err_o, 0);
        chk("rst_req_ready", bif.req_ready_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", bif.req_ready_o, 1);

        // 1: zero-wait read from slave 1
        ws = 0; s_rdata = 32'hA5A5_0001; s_err = 1'b0;
        sb.push_back('{32'hA5A5_0001, 1'b0});
        send(32'h0000_1004, 1'b0, 32'h0);
        @(negedge clk);
        chk("t1_psel", bif.psel_o, 4'b0010);
        chk("t1_paddr", bif.paddr_o, 12'h004);
        chk("t1_setup_penable", bif.penable_o, 0);
        wait_rsp(lat);
        chk("t1_latency", lat, 3);
        finish_hs();

        // 2: write with three wait states
        ws = 3; s_rdata = 32'h1111_2222;
        sb.push_back('{32'h0, 1'b0});
        send(32'h0000_0008, 1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_pwrite", bif.pwrite_o, 1);
            chk("t2_pwdata", bif.pwdata_o, 32'hDEAD_BEEF);
            chk("t2_psel", bif.psel_o, 4'b0001);
        end
        wait_rsp(lat);
        chk("t2_latency", lat, 6);
        finish_hs();

        // 3: decode error from upper address bits
        ws = 0;
        sb.push_back('{32'h0, 1'b1});
        send(32'h0001_0000, 1'b0, 32'h0);
        chk("t3_psel", bif.psel_o, 0);
        wait_rsp(lat);
        chk("t3_latency", lat, 1);
        finish_hs();

        // 4: stalled slave hits the watchdog
        stuck = 1'b1; s_rdata = 32'h1234_5678;
        sb.push_back('{32'h0, 1'b1});
        send(32'h0000_2000, 1'b0, 32'h0);
        n_acc = 0;
        for (int i = 0; i < 40 && !bif.rsp_valid_o; i++) begin
            @(negedge clk);
            if ((bif.psel_o != 0) && bif.penable_o) n_acc++;
        end
        chk("t4_access_cycles", n_acc, 8);
        wait_rsp(lat);
        chk("t4_latency", lat, 10);
        chk("t4_psel_dropped", bif.psel_o, 0);
        finish_hs();
        stuck = 1'b0;

        // 5: slave error, response held off by the host
        ws = 0; s_rdata = 32'h5555_AAAA; s_err = 1'b1;
        bif.rsp_ready_i = 1'b0;
        sb.push_back('{32'h5555_AAAA, 1'b1});
        send(32'h0000_3010, 1'b0, 32'h0);
        wait_rsp(lat);
        chk("t5_latency", lat, 3);
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_valid", bif.rsp_valid_o, 1);
            chk("t5_hold_rdata", bif.rsp_rdata_o, 32'h5555_AAAA);
            chk("t5_hold_err", bif.rsp_err_o, 1);
            chk("t5_req_ready", bif.req_ready_o, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bif.rsp_ready_i = 1'b1;
        s_err = 1'b0;
        @(negedge clk);
        finish_hs();
        chk("t5_idle_ready", bif.req_ready_o, 1);

        // 6: reset during ACCESS discards the transfer
        ws = 5; s_rdata = 32'h7777_0000;
        send(32'h0000_1020, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_access", bif.penable_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_psel", bif.psel_o, 0);
        chk("t6_rst_penable", bif.penable_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", bif.rsp_valid_o, 0);
        end
        ws = 0; s_rdata = 32'hCAFE_0006;
        sb.push_back('{32'hCAFE_0006, 1'b0});
        send(32'h0000_1004, 1'b0, 32'h0);
        wait_rsp(lat);
        chk("t6_next_latency", lat, 3);
        finish_hs();

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
